multicycle_controller: RTL and testbench

- Control FSM that sequences the 32-bit MIPS datapath (pc, inst/data memory, reg_file, alu, sign_extension, shl2, muxes) as a multi-cycle processor.
- Decodes opcode and funct, and drives every mux select, write enable and the 3-bit alu_op, one state per cycle.
- Keeps a retired-instruction counter and a sticky illegal-instruction flag for the testbench.

---
 rtl/multicycle_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a 32-bit multi-cycle MIPS datapath. Sequences fetch, decode,
// execute, memory and write-back one state per cycle. Drives every mux select,
// write enable and alu_op. Also keeps a retired-instruction counter and a
// sticky illegal-instruction flag.
module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b0,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXEC  = 4'd6,
    S_R_WB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI    = 4'd9,
    S_I_WB    = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12,
    S_SLTI    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b110;
  localparam logic [2:0] ALU_OR  = 3'b111;
  localparam logic [2:0] ALU_XOR = 3'b001;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_r;
  state_t           next_state_s;
  logic             illegal_r;
  logic [CNT_W-1:0] retired_count_r;

  logic             funct_legal_s;
  logic [2:0]       r_alu_op_s;
  logic             dec_illegal_s;
  logic             retire_s;

  // Map the R-type funct field to an ALU operation and flag unsupported ones.
  always_comb begin
    funct_legal_s = 1'b1;
    r_alu_op_s    = ALU_ADD;
    case (funct)
      6'b100000: r_alu_op_s = ALU_ADD;
      6'b100010: r_alu_op_s = ALU_SUB;
      6'b100100: r_alu_op_s = ALU_AND;
      6'b100101: r_alu_op_s = ALU_OR;
      6'b100110: r_alu_op_s = ALU_XOR;
      6'b101010: r_alu_op_s = ALU_SLT;
      default: begin
        funct_legal_s = 1'b0;
        r_alu_op_s    = ALU_ADD;
      end
    endcase
  end

  // Classify the opcode as illegal (unknown opcode, or R-type with bad funct).
  always_comb begin
    dec_illegal_s = 1'b0;
    case (opcode)
      OP_RTYPE: dec_illegal_s = ~funct_legal_s;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J: dec_illegal_s = 1'b0;
      default: dec_illegal_s = 1'b1;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: retire_s = 1'b1;
      default: retire_s = 1'b0;
    endcase
  end

  // Next-state selection; the opcode is sampled live since the IR holds after FETCH.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: next_state_s = S_DECODE;
      S_DECODE: begin
        if (dec_illegal_s) begin
          next_state_s = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        end else begin
          case (opcode)
            OP_RTYPE:    next_state_s = S_R_EXEC;
            OP_LW, OP_SW: next_state_s = S_MEM_ADR;
            OP_BEQ:      next_state_s = S_BRANCH;
            OP_ADDI:     next_state_s = S_ADDI;
            OP_SLTI:     next_state_s = S_SLTI;
            OP_J:        next_state_s = S_JUMP;
            default:     next_state_s = S_FETCH;
          endcase
        end
      end
      S_MEM_ADR: begin
        if (opcode == OP_LW) begin
          next_state_s = S_MEM_RD;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_MEM_RD: next_state_s = S_MEM_WB;
      S_MEM_WB: next_state_s = S_FETCH;
      S_MEM_WR: next_state_s = S_FETCH;
      S_R_EXEC: next_state_s = S_R_WB;
      S_R_WB:   next_state_s = S_FETCH;
      S_BRANCH: next_state_s = S_FETCH;
      S_ADDI:   next_state_s = S_I_WB;
      S_SLTI:   next_state_s = S_I_WB;
      S_I_WB:   next_state_s = S_FETCH;
      S_JUMP:   next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // State register, sticky illegal flag and retired counter; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_FETCH;
      illegal_r       <= 1'b0;
      retired_count_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE && dec_illegal_s) begin
        illegal_r <= 1'b1;
      end
      if (retire_s) begin
        retired_count_r <= retired_count_r + CNT_ONE;
      end
    end
  end

  // Moore output decode from the current state; only pc_en in BRANCH follows zero.
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_src     = 2'b00;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_en     = 1'b1;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op_s;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      S_ADDI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_SLTI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_SLT;
      end
      S_I_WB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      S_HALT: alu_op = 3'b000;
      default: alu_op = ALU_ADD;
    endcase
  end

  assign state         = state_r;
  assign illegal       = illegal_r;
  assign retired_count = retired_count_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus queues one expected
// snapshot per cycle, and a negedge monitor pops and compares it against the DUT.
// Two instances cover both illegal-instruction policies.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic [5:0] opcode, funct;
  logic       zero;

  logic        pc_en0, iord0, mr0, mw0, irw0, rd0, m2r0, rw0, asa0, ill0;
  logic [1:0]  asb0, ps0;
  logic [2:0]  op0;
  logic [3:0]  st0;
  logic [31:0] cnt0;
  logic        pc_en1, iord1, mr1, mw1, irw1, rd1, m2r1, rw1, asa1, ill1;
  logic [1:0]  asb1, ps1;
  logic [2:0]  op1;
  logic [3:0]  st1;
  logic [31:0] cnt1;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst0), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en0), .iord(iord0), .mem_read(mr0), .mem_write(mw0), .ir_write(irw0),
    .reg_dst(rd0), .mem_to_reg(m2r0), .reg_write(rw0), .alu_src_a(asa0),
    .alu_src_b(asb0), .alu_op(op0), .pc_src(ps0), .state(st0), .illegal(ill0),
    .retired_count(cnt0));

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst1), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en1), .iord(iord1), .mem_read(mr1), .mem_write(mw1), .ir_write(irw1),
    .reg_dst(rd1), .mem_to_reg(m2r1), .reg_write(rw1), .alu_src_a(asa1),
    .alu_src_b(asb1), .alu_op(op1), .pc_src(ps1), .state(st1), .illegal(ill1),
    .retired_count(cnt1));

  logic [15:0] ctrl0, ctrl1;
  assign ctrl0 = {pc_en0, iord0, mr0, mw0, irw0, rd0, m2r0, rw0, asa0, asb0, op0, ps0};
  assign ctrl1 = {pc_en1, iord1, mr1, mw1, irw1, rd1, m2r1, rw1, asa1, asb1, op1, ps1};

  typedef struct {
    bit          sel;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
    logic [31:0] cnt;
    string       nm;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt [2];
  logic        exp_ill [2];

  // Hand-written control word per state:
  // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,pc_src}
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [2:0] r_op, input logic z);
    case (st)
      4'd0:  return 16'b1_0_1_0_1_0_0_0_0_01_010_00;
      4'd1:  return 16'b0_0_0_0_0_0_0_0_0_11_010_00;
      4'd2:  return 16'b0_0_0_0_0_0_0_0_1_10_010_00;
      4'd3:  return 16'b0_1_1_0_0_0_0_0_0_00_010_00;
      4'd4:  return 16'b0_0_0_0_0_0_1_1_0_00_010_00;
      4'd5:  return 16'b0_1_0_1_0_0_0_0_0_00_010_00;
      4'd6:  return {8'b0000_0000, 1'b1, 2'b00, r_op, 2'b00};
      4'd7:  return 16'b0_0_0_0_0_1_0_1_0_00_010_00;
      4'd8:  return {z, 7'b000_0000, 1'b1, 2'b00, 3'b011, 2'b01};
      4'd9:  return 16'b0_0_0_0_0_0_0_0_1_10_010_00;
      4'd10: return 16'b0_0_0_0_0_0_0_1_0_00_010_00;
      4'd11: return 16'b1_0_0_0_0_0_0_0_0_00_010_10;
      4'd12: return 16'b0;
      4'd13: return 16'b0_0_0_0_0_0_0_0_1_10_100_00;
      default: return 16'b0_0_0_0_0_0_0_0_0_00_010_00;
    endcase
  endfunction

  task automatic push_exp(input bit sel, input logic [3:0] st, input logic [2:0] r_op, input string nm);
    exp_t e;
    e.sel  = sel;
    e.st   = st;
    e.ctrl = exp_ctrl(st, r_op, zero);
    e.ill  = exp_ill[sel];
    e.cnt  = exp_cnt[sel];
    e.nm   = nm;
    sb_q.push_back(e);
  endtask

  // Issue one instruction starting in a FETCH cycle; seq holds the state list, low nibble first.
  task automatic run_instr(input bit sel, input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic [23:0] seq, input int n, input logic [2:0] r_op,
                           input bit retires, input bit illg, input string nm);
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int i = 0; i < n; i++) push_exp(sel, seq[4*i +: 4], r_op, nm);
    repeat (n) @(posedge clk);
    #1;
    if (retires) exp_cnt[sel] = exp_cnt[sel] + 32'd1;
    if (illg) exp_ill[sel] = 1'b1;
  endtask

  // Monitor: one expected snapshot per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t        e;
      logic [3:0]  a_st;
      logic [15:0] a_ctrl;
      logic        a_ill;
      logic [31:0] a_cnt;
      e      = sb_q.pop_front();
      a_st   = e.sel ? st1 : st0;
      a_ctrl = e.sel ? ctrl1 : ctrl0;
      a_ill  = e.sel ? ill1 : ill0;
      a_cnt  = e.sel ? cnt1 : cnt0;
      checks = checks + 4;
      if (a_st !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", e.nm, a_st, e.st);
      end
      if (a_ctrl !== e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl (st %0d): got %b expected %b", e.nm, e.st, a_ctrl, e.ctrl);
      end
      if (a_ill !== e.ill) begin
        errors++;
        $display("FAIL %s illegal (st %0d): got %b expected %b", e.nm, e.st, a_ill, e.ill);
      end
      if (a_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s retired_count (st %0d): got %0d expected %0d", e.nm, e.st, a_cnt, e.cnt);
      end
    end
  end

  // Directed stimulus.
  initial begin
    exp_cnt[0] = 32'd0; exp_cnt[1] = 32'd0;
    exp_ill[0] = 1'b0;  exp_ill[1] = 1'b0;
    opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;

    run_instr(1'b0, 6'b100011, 6'b000000, 1'b0, 24'h043210, 5, 3'b010, 1'b1, 1'b0, "lw");
    run_instr(1'b0, 6'b101011, 6'b000000, 1'b0, 24'h005210, 4, 3'b010, 1'b1, 1'b0, "sw");
    run_instr(1'b0, 6'b000000, 6'b100110, 1'b0, 24'h007610, 4, 3'b001, 1'b1, 1'b0, "r_xor");
    run_instr(1'b0, 6'b000000, 6'b101010, 1'b0, 24'h007610, 4, 3'b100, 1'b1, 1'b0, "r_slt");
    run_instr(1'b0, 6'b000000, 6'b100010, 1'b0, 24'h007610, 4, 3'b011, 1'b1, 1'b0, "r_sub");
    run_instr(1'b0, 6'b000100, 6'b000000, 1'b1, 24'h000810, 3, 3'b010, 1'b1, 1'b0, "beq_taken");
    run_instr(1'b0, 6'b000100, 6'b000000, 1'b0, 24'h000810, 3, 3'b010, 1'b1, 1'b0, "beq_not");
    run_instr(1'b0, 6'b000010, 6'b000000, 1'b0, 24'h000B10, 3, 3'b010, 1'b1, 1'b0, "j");
    run_instr(1'b0, 6'b001010, 6'b000000, 1'b0, 24'h00AD10, 4, 3'b010, 1'b1, 1'b0, "slti");
    run_instr(1'b0, 6'b001000, 6'b000000, 1'b0, 24'h00A910, 4, 3'b010, 1'b1, 1'b0, "addi");
    run_instr(1'b0, 6'b111111, 6'b000000, 1'b0, 24'h000010, 2, 3'b010, 1'b0, 1'b1, "ill_op");
    run_instr(1'b0, 6'b000000, 6'b111111, 1'b0, 24'h000010, 2, 3'b010, 1'b0, 1'b1, "ill_funct");
    run_instr(1'b0, 6'b000000, 6'b100000, 1'b0, 24'h007610, 4, 3'b010, 1'b1, 1'b0, "r_add_after_ill");

    // Reset held for two cycles in the middle of R_EXEC.
    opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
    push_exp(1'b0, 4'd0, 3'b010, "rst_mid");
    push_exp(1'b0, 4'd1, 3'b010, "rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b1;
    push_exp(1'b0, 4'd6, 3'b010, "rst_mid");
    exp_cnt[0] = 32'd0;
    exp_ill[0] = 1'b0;
    push_exp(1'b0, 4'd0, 3'b010, "rst_held");
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    run_instr(1'b0, 6'b000010, 6'b000000, 1'b0, 24'h000B10, 3, 3'b010, 1'b1, 1'b0, "after_rst_j");
    run_instr(1'b0, 6'b000100, 6'b000000, 1'b1, 24'h000810, 3, 3'b010, 1'b1, 1'b0, "after_rst_beq");

    // HALT_ON_ILLEGAL=1 instance: illegal parks in HALT until rst.
    rst1 = 1'b0;
    run_instr(1'b1, 6'b111111, 6'b000000, 1'b0, 24'h000010, 2, 3'b010, 1'b0, 1'b1, "halt_entry");
    for (int i = 0; i < 10; i++) push_exp(1'b1, 4'd12, 3'b010, "halt_hold");
    repeat (10) @(posedge clk);
    #1;
    rst1 = 1'b1;
    push_exp(1'b1, 4'd12, 3'b010, "halt_rst_cycle");
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    opcode = 6'b000010;
    exp_ill[1] = 1'b0;
    exp_cnt[1] = 32'd0;
    run_instr(1'b1, 6'b000010, 6'b000000, 1'b0, 24'h000B10, 3, 3'b010, 1'b1, 1'b0, "halt_cleared_j");

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
